ezm_prog_feeder: RTL and testbench
==================================

// Module: ezm_prog_feeder
// PURPOSE
// Host-side instruction server for the ezm 6-bit-in/8-bit-out accumulator core. Holds a loadable program RAM,
// drives the core's instruction input from the pc it exports, and harvests results:
// store traffic into a small FIFO, plus the final accumulator.
// Sits between the host/test harness and the core; owns the core's reset.
// PARAMETERS
// AW          6    program RAM address width (depth 2**AW words x 6 bits)
// FIFO_DEPTH  4    result FIFO entries (power of 2)
// MAX_INSTR   255  instruction budget per run before forced stop
// PORTS
// clk         in   1   clock
// rst         in   1   reset, synchronous, active-high
// prog_we     in   1   program write strobe (honoured in IDLE/DONE only)
// prog_addr   in   AW  program write address
// prog_data   in   6   program word
// prog_len    in   8   instruction count; latched on start; valid range 0..2**AW
// start       in   1   run request pulse (honoured in IDLE/DONE only)
// busy        out  1   run in progress
// done        out  1   run finished (sticky until next start/rst)
// timeout     out  1   run stopped by MAX_INSTR budget
// overflow    out  1   store dropped because FIFO was full (sticky per run)
// final_acc   out  8   accumulator captured at halt
// instr_count out  8   instructions issued this run (saturating at 255)
// res_valid   out  1   FIFO head valid
// res_bank    out  3   register index of store
// res_data    out  8   stored value
// res_ready   in   1   pop FIFO head when res_valid & res_ready
// cpu_rst     out  1   to core rst
// cpu_out     in   8   from core out_o (pc in fetch phase, acc in execute phase)
// cpu_in      out  6   to core in_i
// BEHAVIOUR
// - Reset: state IDLE; cpu_rst=1, cpu_in=0, busy=0, done=0, timeout=0, overflow=0, final_acc=0, instr_count=0,
//   FIFO empty, res_valid=0. Program RAM is NOT cleared.
// - FSM: IDLE -> RST1 -> RST2 -> FETCH <-> EXEC ... -> DONE. start in IDLE/DONE: clear done/timeout/overflow/
//   instr_count/FIFO, latch prog_len, go RST1. RST1/RST2: cpu_rst=1, busy=1. First cycle with cpu_rst=0 is FETCH
//   (core phase 0); phases then alternate one per cycle.
// - FETCH: cpu_out is pc. Halt if pc >= latched prog_len (unsigned, 8-bit; pc wrap from branch underflow halts) or
//   instr_count==MAX_INSTR (also sets timeout). Non-halt: cpu_in = mem[pc[AW-1:0]] (async read, same cycle),
//   ir <= that word, instr_count++. Halt: cpu_in=0 (no-op), halting flag set.
// - EXEC: cpu_in = ir (held stable). If ir[5:3]==3'b001 (store) push {ir[2:0], cpu_out}; FIFO full -> drop, overflow=1.
//   If halting: final_acc <= cpu_out, go DONE; else go FETCH.
// - DONE: cpu_rst=1, busy=0, done=1; FIFO drains normally.
// - Latency: done rises 2*(prog_len+1)+3 cycles after start edge for a branch-free program.
// - FIFO: push and pop in same cycle while full -> both succeed, no overflow. Pop on empty ignored.
// - prog_we / start while busy: ignored. Simultaneous prog_we and start in IDLE: write completes, run uses new word.
// - rst mid-run: next cycle IDLE, cpu_rst=1, FIFO flushed, flags cleared; RAM retained.
// STRUCTURE
// - Package ezm_pkg: opcode masks (LOAD 1xxxxx, BRANCH 011xxx, STORE 001xxx, ADD 010xxx, NEG 000001),
//   feeder state enum, result entry typedef {bank[2:0], data[7:0]}.
// - Sub-module ezm_result_fifo (FIFO_DEPTH x 11 bits, valid/ready pop, full/empty flags).
// - Top: program RAM, FSM, ir, counters, flag registers.
// TESTING
// 1. Prog {100101 LOAD 5, 001010 STORE r2, 010010 ADD r2}, len=3, res_ready=1 -> one entry {2,0x05}; final_acc=0x0A;
//    instr_count=3; done exactly 11 cycles after start edge.
// 2. Prog {110000 LOAD -16, 000001 NEG}, len=2 -> final_acc=0x0F, no FIFO entries, timeout=0.
// 3. Infinite loop (LOAD 1, STORE r0, LOAD 0, BRANCH r0), MAX_INSTR=20 -> timeout=1, instr_count=20, done=1.
// 4. Five STOREs of LOAD values 1..5 to r0, res_ready=0 -> 4 entries data 1,2,3,4 in order, overflow=1.
// 5. rst asserted 6 cycles into test 1 -> next cycle cpu_rst=1, busy=0, res_valid=0; restart gives test 1 results.
// 6. prog_we to addr 0 while busy -> RAM unchanged; rerun yields identical final_acc.

Source files
------------

// File: rtl/ezm_pkg.sv
// Shared definitions for the ezm instruction feeder: opcode masks, feeder
// state encoding and the result entry format carried by the result FIFO.
package ezm_pkg;

  localparam int INSTR_W = 6;
  localparam int DATA_W  = 8;

  // Opcode classes are recognised by (word & MASK) == VAL.
  localparam logic [INSTR_W-1:0] OP_LOAD_MASK   = 6'b100000;
  localparam logic [INSTR_W-1:0] OP_LOAD_VAL    = 6'b100000;
  localparam logic [INSTR_W-1:0] OP_BRANCH_MASK = 6'b111000;
  localparam logic [INSTR_W-1:0] OP_BRANCH_VAL  = 6'b011000;
  localparam logic [INSTR_W-1:0] OP_STORE_MASK  = 6'b111000;
  localparam logic [INSTR_W-1:0] OP_STORE_VAL   = 6'b001000;
  localparam logic [INSTR_W-1:0] OP_ADD_MASK    = 6'b111000;
  localparam logic [INSTR_W-1:0] OP_ADD_VAL     = 6'b010000;
  localparam logic [INSTR_W-1:0] OP_NEG_MASK    = 6'b111111;
  localparam logic [INSTR_W-1:0] OP_NEG_VAL     = 6'b000001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST1  = 3'd1,
    ST_RST2  = 3'd2,
    ST_FETCH = 3'd3,
    ST_EXEC  = 3'd4,
    ST_DONE  = 3'd5
  } feeder_state_t;

  typedef struct packed {
    logic [2:0]        bank;
    logic [DATA_W-1:0] data;
  } result_t;

  function automatic logic is_store(input logic [INSTR_W-1:0] word);
    return (word & OP_STORE_MASK) == OP_STORE_VAL;
  endfunction

endpackage

// File: rtl/ezm_result_fifo.sv
// Small result FIFO holding store traffic from the core. A push while full is
// accepted only when the head is popped in the same cycle; the caller decides
// what a refused push means. Popping an empty FIFO does nothing.
module ezm_result_fifo
  import ezm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    push,
  input  result_t push_data,
  input  logic    pop,
  output result_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  result_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            pop_fire;
  logic            push_fire;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign pop_fire  = pop & ~empty;
  assign push_fire = push & (~full | pop_fire);
  assign head      = mem[rd_ptr];

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ezm_prog_feeder.sv
// Host-side instruction server for the ezm accumulator core. Holds the
// program RAM, feeds the core one instruction per fetch/execute pair using
// the pc the core exports, and collects store results and the final
// accumulator.
//
// Result handshake: an entry is transferred on any rising clk edge where
// res_valid and res_ready are both high; res_valid stays high and
// res_bank/res_data stay stable until that transfer happens.
module ezm_prog_feeder
  import ezm_pkg::*;
#(
  parameter int AW         = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_INSTR  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [INSTR_W-1:0]  prog_data,
  input  logic [7:0]          prog_len,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic                overflow,
  output logic [DATA_W-1:0]   final_acc,
  output logic [7:0]          instr_count,
  output logic                res_valid,
  output logic [2:0]          res_bank,
  output logic [DATA_W-1:0]   res_data,
  input  logic                res_ready,
  output logic                cpu_rst,
  input  logic [DATA_W-1:0]   cpu_out,
  output logic [INSTR_W-1:0]  cpu_in,
  output logic [2:0]          dbg_state
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_INSTR);

  feeder_state_t        state;
  logic [INSTR_W-1:0]   prog_mem [2**AW];
  logic [INSTR_W-1:0]   ir;
  logic [7:0]           prog_len_q;
  logic                 halting;
  logic                 idle_like;
  logic                 pc_halt;
  logic                 budget_halt;
  logic [INSTR_W-1:0]   fetch_word;
  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 fifo_flush;
  result_t              fifo_head;
  result_t              push_entry;

  assign idle_like   = (state == ST_IDLE) || (state == ST_DONE);
  assign pc_halt     = (cpu_out >= prog_len_q);
  assign budget_halt = (instr_count == MAX_CNT);
  assign fetch_word  = prog_mem[cpu_out[AW-1:0]];
  assign dbg_state   = state;

  // Drive the core's instruction input: memory word on a live fetch, the held
  // ir during execute, and a no-op everywhere else (including a halting fetch).
  always_comb begin
    cpu_in = '0;
    if (state == ST_FETCH && !pc_halt && !budget_halt) cpu_in = fetch_word;
    else if (state == ST_EXEC)                         cpu_in = ir;
  end

  // Program RAM write port; the program is frozen while a run is in flight.
  always_ff @(posedge clk) begin
    if (prog_we && idle_like) prog_mem[prog_addr] <= prog_data;
  end

  assign fifo_push       = (state == ST_EXEC) && is_store(ir);
  assign push_entry.bank = ir[2:0];
  assign push_entry.data = cpu_out;
  assign fifo_pop        = res_ready;
  assign fifo_flush      = start && idle_like;
  assign res_valid       = ~fifo_empty;
  assign res_bank        = fifo_head.bank;
  assign res_data        = fifo_head.data;

  ezm_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Run sequencer: core reset, fetch/execute alternation, halt and flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cpu_rst     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      final_acc   <= '0;
      instr_count <= '0;
      prog_len_q  <= '0;
      ir          <= '0;
      halting     <= 1'b0;
    end else begin
      // A store refused because the FIFO stays full is lost; remember that.
      if (fifo_push && fifo_full && !(res_ready && res_valid)) overflow <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_RST1;
            cpu_rst     <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
            instr_count <= '0;
            prog_len_q  <= prog_len;
            halting     <= 1'b0;
            ir          <= '0;
          end
        end
        ST_RST1: state <= ST_RST2;
        ST_RST2: begin
          state   <= ST_FETCH;
          cpu_rst <= 1'b0;
        end
        ST_FETCH: begin
          state <= ST_EXEC;
          if (pc_halt || budget_halt) begin
            halting <= 1'b1;
            ir      <= '0;
            // Running off the end of the program is a normal finish even if
            // the budget happens to be exhausted at the same moment.
            if (!pc_halt) timeout <= 1'b1;
          end else begin
            ir <= fetch_word;
            if (instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
          end
        end
        ST_EXEC: begin
          if (halting) begin
            final_acc <= cpu_out;
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_rst   <= 1'b1;
          end else begin
            state <= ST_FETCH;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cpu_rst <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ezm_prog_feeder.sv
// Bench for ezm_prog_feeder: a behavioural ezm core answers the feeder's
// instruction stream, an ISA-level reference run of each program fills the
// expected result queue, and a monitor compares every popped FIFO entry.
module tb_ezm_prog_feeder;

  localparam int AW    = 6;
  localparam int DEPTH = 4;
  localparam int MAXI  = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic           prog_we;
  logic [AW-1:0]  prog_addr;
  logic [5:0]     prog_data;
  logic [7:0]     prog_len;
  logic           start;
  logic           busy, done, timeout, overflow;
  logic [7:0]     final_acc, instr_count;
  logic           res_valid;
  logic [2:0]     res_bank;
  logic [7:0]     res_data;
  logic           res_ready;
  logic           cpu_rst;
  logic [7:0]     cpu_out;
  logic [5:0]     cpu_in;
  logic [2:0]     dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] exp_q[$];
  logic [5:0]  prog_mirror [64];
  logic [7:0]  exp_acc, exp_count;
  logic        exp_timeout, exp_overflow;

  ezm_prog_feeder #(.AW(AW), .FIFO_DEPTH(DEPTH), .MAX_INSTR(MAXI)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .busy(busy),
    .done(done), .timeout(timeout), .overflow(overflow), .final_acc(final_acc),
    .instr_count(instr_count), .res_valid(res_valid), .res_bank(res_bank),
    .res_data(res_data), .res_ready(res_ready), .cpu_rst(cpu_rst),
    .cpu_out(cpu_out), .cpu_in(cpu_in), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural ezm core ----------------
  logic [7:0] c_pc, c_acc;
  logic [7:0] c_regs [8];
  logic       c_phase;
  assign cpu_out = c_phase ? c_acc : c_pc;

  always @(posedge clk) begin
    if (cpu_rst) begin
      c_pc <= 8'd0; c_acc <= 8'd0; c_phase <= 1'b0;
      for (int i = 0; i < 8; i++) c_regs[i] <= 8'd0;
    end else if (!c_phase) begin
      c_phase <= 1'b1;
    end else begin
      c_phase <= 1'b0;
      c_pc    <= c_pc + 8'd1;
      if (cpu_in[5]) c_acc <= {{3{cpu_in[4]}}, cpu_in[4:0]};
      else if (cpu_in[5:3] == 3'b011) begin
        if (c_acc == 8'd0) c_pc <= c_pc - c_regs[cpu_in[2:0]];
      end
      else if (cpu_in[5:3] == 3'b001) c_regs[cpu_in[2:0]] <= c_acc;
      else if (cpu_in[5:3] == 3'b010) c_acc <= c_acc + c_regs[cpu_in[2:0]];
      else if (cpu_in == 6'b000001)   c_acc <= ~c_acc;
    end
  end

  // ---------------- result monitor ----------------
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL res_unexpected: got bank=%0d data=%02h, expected no entry", res_bank, res_data);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if ({res_bank, res_data} !== e) begin
          n_errors++;
          $display("FAIL res_entry: got bank=%0d data=%02h, expected bank=%0d data=%02h",
                   res_bank, res_data, e[10:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- reference + drivers ----------------
  // ISA-level run of the mirrored program; fills exp_q and the expected flags.
  task automatic ref_run(input logic [7:0] len, input bit keep_all);
    logic [7:0] pc, acc, cnt;
    logic [7:0] regs [8];
    logic [5:0] w;
    int         stored;
    pc = 0; acc = 0; cnt = 0; stored = 0;
    exp_timeout = 0; exp_overflow = 0;
    for (int i = 0; i < 8; i++) regs[i] = 0;
    while (1) begin
      if (pc >= len) break;
      if (cnt == 8'(MAXI)) begin exp_timeout = 1; break; end
      w = prog_mirror[pc[5:0]];
      cnt++;
      if (w[5]) begin acc = {{3{w[4]}}, w[4:0]}; pc++; end
      else if (w[5:3] == 3'b011) pc = (acc == 0) ? pc - regs[w[2:0]] : pc + 1;
      else if (w[5:3] == 3'b001) begin
        regs[w[2:0]] = acc;
        if (keep_all || stored < DEPTH) exp_q.push_back({w[2:0], acc});
        else exp_overflow = 1;
        stored++;
        pc++;
      end
      else if (w[5:3] == 3'b010) begin acc = acc + regs[w[2:0]]; pc++; end
      else if (w == 6'b000001) begin acc = ~acc; pc++; end
      else pc++;
    end
    exp_acc = acc; exp_count = cnt;
  endtask

  task automatic write_word(input int addr, input logic [5:0] data);
    prog_we = 1; prog_addr = AW'(addr); prog_data = data;
    @(posedge clk); #1;
    prog_we = 0;
    prog_mirror[addr] = data;
  endtask

  // Waits for done; cycles counts posedges from the one that samples start.
  task automatic wait_done(output int cycles);
    bit seen;
    seen = 0; cycles = 1;
    while (!seen && cycles < 2000) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin @(posedge clk); #1; cycles++; end
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL done_wait: got no done after %0d cycles, expected done", cycles);
    end
  endtask

  task automatic run_prog(input logic [7:0] len, output int cycles);
    start = 1; prog_len = len;
    @(posedge clk); #1;
    start = 0;
    wait_done(cycles);
  endtask

  task automatic check_run(input string tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (final_acc !== exp_acc) begin n_errors++;
      $display("FAIL %s final_acc: got %02h expected %02h", tag, final_acc, exp_acc); end
    n_checks++;
    if (instr_count !== exp_count) begin n_errors++;
      $display("FAIL %s instr_count: got %0d expected %0d", tag, instr_count, exp_count); end
    n_checks++;
    if ({done, busy, timeout, overflow} !== {1'b1, 1'b0, exp_timeout, exp_overflow}) begin n_errors++;
      $display("FAIL %s flags: got done/busy/to/ovf=%b expected %b", tag,
               {done, busy, timeout, overflow}, {1'b1, 1'b0, exp_timeout, exp_overflow}); end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++;
      $display("FAIL %s results_left: got %0d undelivered, expected 0", tag, exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic load_test1();
    write_word(0, 6'b100101);
    write_word(1, 6'b001010);
    write_word(2, 6'b010010);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({cpu_rst, cpu_in, busy, done, timeout, overflow, final_acc, instr_count, res_valid, dbg_state}
        !== {1'b1, 6'd0, 4'b0000, 8'd0, 8'd0, 1'b0, 3'd0}) begin
      n_errors++;
      $display("FAIL reset_state: got rst=%b in=%0d busy=%b done=%b to=%b ovf=%b acc=%02h cnt=%0d rv=%b st=%0d, expected 1,0,0,0,0,0,00,0,0,0",
               cpu_rst, cpu_in, busy, done, timeout, overflow, final_acc, instr_count, res_valid, dbg_state);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_basic_store();
    int cyc;
    load_test1();
    res_ready = 1;
    ref_run(8'd3, 1);
    run_prog(8'd3, cyc);
    n_checks++;
    if (cyc != 11) begin n_errors++;
      $display("FAIL basic_latency: got %0d cycles, expected 11", cyc); end
    check_run("basic");
  endtask

  task automatic test_neg();
    int cyc;
    write_word(0, 6'b110000);
    write_word(1, 6'b000001);
    ref_run(8'd2, 1);
    run_prog(8'd2, cyc);
    n_checks++;
    if (final_acc !== 8'h0F) begin n_errors++;
      $display("FAIL neg_value: got %02h expected 0F", final_acc); end
    check_run("neg");
  endtask

  task automatic test_timeout();
    int cyc;
    write_word(0, 6'b100001);
    write_word(1, 6'b001000);
    write_word(2, 6'b100000);
    write_word(3, 6'b011000);
    ref_run(8'd4, 1);
    run_prog(8'd4, cyc);
    n_checks++;
    if ({timeout, instr_count} !== {1'b1, 8'd20}) begin n_errors++;
      $display("FAIL timeout_budget: got to=%b cnt=%0d expected to=1 cnt=20", timeout, instr_count); end
    check_run("timeout");
  endtask

  task automatic test_overflow();
    int cyc;
    for (int i = 0; i < 5; i++) begin
      write_word(2*i, {1'b1, 5'(i + 1)});
      write_word(2*i + 1, 6'b001000);
    end
    res_ready = 0;
    ref_run(8'd10, 0);
    run_prog(8'd10, cyc);
    @(negedge clk);
    n_checks++;
    if ({overflow, res_valid} !== 2'b11) begin n_errors++;
      $display("FAIL ovf_hold: got ovf=%b valid=%b expected 1 1", overflow, res_valid); end
    @(posedge clk); #1;
    res_ready = 1;
    repeat (6) @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) begin n_errors++;
      $display("FAIL ovf_drain: got valid=%b expected 0", res_valid); end
    check_run("overflow");
  endtask

  task automatic test_midrun_reset();
    int cyc;
    for (int i = 0; i < 10; i++) prog_mirror[i] = 6'b000000;
    load_test1();
    res_ready = 0;
    start = 1; prog_len = 8'd3;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_rst, busy, res_valid, done, dbg_state} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin n_errors++;
      $display("FAIL midrun_reset: got cpu_rst=%b busy=%b valid=%b done=%b st=%0d expected 1 0 0 0 0",
               cpu_rst, busy, res_valid, done, dbg_state); end
    rst = 0;
    res_ready = 1;
    ref_run(8'd3, 1);
    run_prog(8'd3, cyc);
    n_checks++;
    if (cyc != 11) begin n_errors++;
      $display("FAIL restart_latency: got %0d cycles, expected 11", cyc); end
    check_run("restart");
  endtask

  task automatic test_write_while_busy();
    int cyc;
    ref_run(8'd3, 1);
    start = 1; prog_len = 8'd3;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk); #1;
    prog_we = 1; prog_addr = '0; prog_data = 6'b110000;
    @(posedge clk); #1;
    prog_we = 0;
    wait_done(cyc);
    check_run("busy_write1");
    ref_run(8'd3, 1);
    run_prog(8'd3, cyc);
    check_run("busy_write2");
  endtask

  task automatic test_write_with_start();
    int cyc;
    write_word(0, 6'b110000);
    write_word(1, 6'b000001);
    prog_mirror[0] = 6'b100011;
    ref_run(8'd2, 1);
    prog_we = 1; prog_addr = '0; prog_data = 6'b100011;
    run_prog(8'd2, cyc);
    prog_we = 0;
    n_checks++;
    if (final_acc !== 8'hFC) begin n_errors++;
      $display("FAIL write_start: got %02h expected FC", final_acc); end
    check_run("write_start");
  endtask

  task automatic test_zero_len();
    int cyc;
    ref_run(8'd0, 1);
    run_prog(8'd0, cyc);
    n_checks++;
    if (cyc != 5) begin n_errors++;
      $display("FAIL zero_latency: got %0d cycles, expected 5", cyc); end
    check_run("zero_len");
  endtask

  task automatic test_random();
    int cyc;
    logic [7:0] len;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 12; i++) begin
        case ($urandom_range(0, 3))
          0: write_word(i, {1'b1, 5'($urandom_range(0, 31))});
          1: write_word(i, {3'b001, 3'($urandom_range(0, 7))});
          2: write_word(i, {3'b010, 3'($urandom_range(0, 7))});
          default: write_word(i, 6'b000001);
        endcase
      end
      len = 8'($urandom_range(1, 12));
      ref_run(len, 1);
      run_prog(len, cyc);
      check_run("random");
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1; prog_we = 0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start = 0; res_ready = 1;
    for (int i = 0; i < 64; i++) prog_mirror[i] = 6'b000000;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) write_word(i, 6'b000000);
    test_reset();
    test_basic_store();
    test_neg();
    test_timeout();
    test_overflow();
    test_midrun_reset();
    test_write_while_busy();
    test_write_with_start();
    test_zero_len();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
